ring_john_monitor: RTL and testbench

//  Sits directly downstream of the 5-bit ring/Johnson counter and consumes its state vector y.
//  - Validates every sample against the legal code set for the current mode.
//  - Decodes the sample to a binary position and checks that it advances by one step per cycle.
//  - Tracks lock with a FSM and counts sequence faults for status/debug logic.

---
 rtl/ring_john_monitor.sv | 150 +++++++++++++++
 tb/tb_ring_john_monitor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_john_monitor.sv
// Monitor for a ring/Johnson counter: validates and decodes each sample, tracks
// sequence lock and counts sequence breaks while locked.
module ring_john_monitor #(
  parameter  int unsigned WIDTH    = 5,
  parameter  int unsigned LOCK_CNT = 4,
  parameter  int unsigned ERRW     = 8,
  localparam int unsigned PW       = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rj,
  input  logic             step_en,
  input  logic [WIDTH-1:0] y_in,
  output logic [PW-1:0]    pos,
  output logic             pos_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             wrap,
  output logic             locked,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam logic [ERRW-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  state_t          state;
  logic [PW-1:0]   prev_pos;
  logic [GW-1:0]   good_cnt;
  logic            rj_q;

  int unsigned     ones;
  logic [WIDTH-1:0] lo_mask;
  logic [WIDTH-1:0] hi_mask;
  logic [PW-1:0]   ring_pos;
  logic            legal;
  logic [PW-1:0]   dec_pos;
  logic [PW:0]     period_w;
  logic [PW:0]     exp_w;
  logic            match;
  logic            mode_chg;

  // Decode the sample in the mode presented this cycle.
  always_comb begin
    ones     = 0;
    ring_pos = '0;
    lo_mask  = '0;
    hi_mask  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + 32'(y_in[i]);
      if (y_in[i]) ring_pos = PW'((WIDTH - i) % WIDTH);
    end
    // Johnson codes are a run of ones anchored at the top or at the bottom.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      lo_mask[i] = (i < ones);
      hi_mask[i] = (i + ones >= WIDTH);
    end
    if (rj) begin
      legal   = (y_in == lo_mask) || (y_in == hi_mask);
      dec_pos = (ones == 0 || y_in[WIDTH-1]) ? PW'(ones) : PW'(2 * WIDTH - ones);
    end else begin
      legal   = (ones == 1);
      dec_pos = ring_pos;
    end
  end

  // Expected position from the previous one, widened so the increment cannot wrap early.
  always_comb begin
    period_w = rj ? (PW+1)'(2 * WIDTH) : (PW+1)'(WIDTH);
    exp_w    = (PW+1)'(prev_pos);
    if (step_en) begin
      exp_w = exp_w + (PW+1)'(1);
      if (exp_w >= period_w) exp_w = exp_w - period_w;
    end
    match    = legal && ((PW+1)'(dec_pos) == exp_w);
    mode_chg = (rj != rj_q);
  end

  // Lock FSM with registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= HUNT;
      prev_pos  <= '0;
      good_cnt  <= '0;
      rj_q      <= rj;
      pos       <= '0;
      pos_valid <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      rj_q      <= rj;
      pos_valid <= legal;
      illegal   <= !legal;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      if (legal) begin
        pos      <= dec_pos;
        prev_pos <= dec_pos;
      end
      if (mode_chg) begin
        state    <= HUNT;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            locked <= 1'b0;
            if (legal) begin
              state    <= TRACK;
              good_cnt <= '0;
            end
          end
          TRACK: begin
            if (!legal) begin
              state <= HUNT;
            end else if (match) begin
              good_cnt <= good_cnt + GW'(1);
              if (good_cnt == GW'(LOCK_CNT - 1)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              wrap <= step_en && ((PW+1)'(prev_pos) == period_w - (PW+1)'(1)) &&
                      (dec_pos == '0);
            end else begin
              state   <= HUNT;
              locked  <= 1'b0;
              seq_err <= 1'b1;
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERRW'(1);
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_john_monitor.sv
// Bench for ring_john_monitor: sequence-table reference model, directed scenarios
// and randomized traffic, with an 8-bit and a 2-bit error counter instance.
module tb_ring_john_monitor;
  localparam int unsigned W  = 5;
  localparam int unsigned LK = 4;
  localparam int unsigned PW = $clog2(2 * W);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rj = 1'b0;
  logic step_en = 1'b1;
  logic [W-1:0] y_in = '0;

  logic [PW-1:0] pos, pos2;
  logic pv, ill, se, wr, lk;
  logic pv2, ill2, se2, wr2, lk2;
  logic [7:0] ec;
  logic [1:0] ec2;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  ring_john_monitor #(.WIDTH(W), .LOCK_CNT(LK), .ERRW(8)) u1 (
    .clk(clk), .rstn(rstn), .rj(rj), .step_en(step_en), .y_in(y_in),
    .pos(pos), .pos_valid(pv), .illegal(ill), .seq_err(se), .wrap(wr),
    .locked(lk), .err_cnt(ec));

  ring_john_monitor #(.WIDTH(W), .LOCK_CNT(LK), .ERRW(2)) u2 (
    .clk(clk), .rstn(rstn), .rj(rj), .step_en(step_en), .y_in(y_in),
    .pos(pos2), .pos_valid(pv2), .illegal(ill2), .seq_err(se2), .wrap(wr2),
    .locked(lk2), .err_cnt(ec2));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Upstream counter step.
  function automatic logic [W-1:0] shift(input logic [W-1:0] y, input logic m);
    return {m ? ~y[0] : y[0], y[W-1:1]};
  endfunction

  // Reference: position is the index of the sample in the upstream walk.
  logic [W-1:0] ring_code[W];
  logic [W-1:0] john_code[2*W];
  initial begin
    logic [W-1:0] t;
    t = W'(1);
    for (int p = 0; p < int'(W); p++) begin ring_code[p] = t; t = shift(t, 1'b0); end
    t = '0;
    for (int p = 0; p < int'(2 * W); p++) begin john_code[p] = t; t = shift(t, 1'b1); end
  end

  int m_st, m_good, m_prev, m_pos, m_err, m_err2;
  bit m_pv, m_ill, m_seq, m_wrap, m_lk, m_rjq;

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_st = 0; m_good = 0; m_prev = 0; m_pos = 0; m_err = 0; m_err2 = 0;
      m_pv = 0; m_ill = 0; m_seq = 0; m_wrap = 0; m_lk = 0; m_rjq = rj;
    end else begin
      int per, e, dp;
      bit lg, good;
      per = rj ? 2 * W : W;
      lg = 0; dp = 0;
      for (int p = 0; p < per; p++)
        if ((rj ? john_code[p] : ring_code[p]) == y_in) begin lg = 1; dp = p; end
      e = step_en ? (m_prev + 1) % per : m_prev;
      good = lg && (dp == e);
      m_seq = 0; m_wrap = 0; m_pv = lg; m_ill = !lg;
      if (lg) m_pos = dp;
      if (rj != m_rjq) begin
        m_st = 0; m_good = 0;
      end else if (m_st == 0) begin
        if (lg) begin m_st = 1; m_good = 0; end
      end else if (m_st == 1) begin
        if (!lg) m_st = 0;
        else if (good) begin m_good++; if (m_good == LK) m_st = 2; end
        else m_good = 0;
      end else begin
        if (good) m_wrap = step_en && (m_prev == per - 1) && (dp == 0);
        else begin
          m_st = 0; m_seq = 1;
          if (m_err < 255) m_err++;
          if (m_err2 < 3) m_err2++;
        end
      end
      if (lg) m_prev = dp;
      m_rjq = rj;
      m_lk = (m_st == 2);
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (run) begin
      chk("pos", int'(pos), m_pos);
      chk("pos_valid", int'(pv), int'(m_pv));
      chk("illegal", int'(ill), int'(m_ill));
      chk("seq_err", int'(se), int'(m_seq));
      chk("wrap", int'(wr), int'(m_wrap));
      chk("locked", int'(lk), int'(m_lk));
      chk("err_cnt", int'(ec), m_err);
      chk("pos_e2", int'(pos2), m_pos);
      chk("locked_e2", int'(lk2), int'(m_lk));
      chk("err_cnt_e2", int'(ec2), m_err2);
    end
  end

  task automatic cyc(input logic [W-1:0] y, input logic m, input logic s);
    y_in = y; rj = m; step_en = s;
    @(negedge clk);
  endtask

  logic [W-1:0] up_y;
  logic mode;

  initial begin
    mode = 1'b0;
    up_y = W'(1);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    run = 1'b1;
    chk("rst_pos", int'(pos), 0);
    chk("rst_pos_valid", int'(pv), 0);
    chk("rst_locked", int'(lk), 0);
    chk("rst_err_cnt", int'(ec), 0);
    rstn = 1'b1;

    // Ring walk from 00001.
    for (int i = 0; i < 12; i++) begin
      if (i > 0) up_y = shift(up_y, 1'b0);
      cyc(up_y, 1'b0, 1'b1);
      chk("ring_pos_lit", int'(pos), i % 5);
      if (i == 3) chk("ring_lock_early", int'(lk), 0);
      if (i == 4) chk("ring_lock_lit", int'(lk), 1);
      if (i == 5 || i == 10) chk("ring_wrap_lit", int'(wr), 1);
      if (i == 6) chk("ring_nowrap_lit", int'(wr), 0);
    end

    // Switch to Johnson while locked, walk from 00000.
    mode = 1'b1;
    up_y = '0;
    for (int i = 0; i < 22; i++) begin
      if (i > 0) up_y = shift(up_y, 1'b1);
      cyc(up_y, 1'b1, 1'b1);
      chk("john_illegal_lit", int'(ill), 0);
      if (i == 0) begin
        chk("modechg_locked", int'(lk), 0);
        chk("modechg_seq_err", int'(se), 0);
        chk("modechg_err_cnt", int'(ec), 0);
      end
      if (up_y == 5'b11111) chk("john_11111_lit", int'(pos), 5);
      if (up_y == 5'b00001) chk("john_00001_lit", int'(pos), 9);
    end
    chk("john_lock_lit", int'(lk), 1);

    // Illegal glitch while locked.
    cyc(5'b01010, 1'b1, 1'b1);
    chk("glitch_illegal", int'(ill), 1);
    chk("glitch_seq_err", int'(se), 1);
    chk("glitch_err_cnt", int'(ec), 1);
    chk("glitch_locked", int'(lk), 0);
    for (int i = 0; i < 10; i++) begin up_y = shift(up_y, 1'b1); cyc(up_y, 1'b1, 1'b1); end
    chk("relock_lit", int'(lk), 1);

    // Frozen counter with step_en low.
    for (int i = 0; i < 10; i++) begin
      cyc(up_y, 1'b1, 1'b0);
      chk("freeze_seq_err", int'(se), 0);
      chk("freeze_locked", int'(lk), 1);
    end
    for (int i = 0; i < 3; i++) begin up_y = shift(up_y, 1'b1); cyc(up_y, 1'b1, 1'b1); end

    // Five faults saturate the 2-bit counter.
    for (int f = 0; f < 5; f++) begin
      cyc(5'b01010, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin up_y = shift(up_y, 1'b1); cyc(up_y, 1'b1, 1'b1); end
    end
    chk("sat_err_cnt_e2", int'(ec2), 3);
    chk("err_cnt_e8", int'(ec), 6);

    // Back to ring while locked.
    up_y = W'(1);
    cyc(up_y, 1'b0, 1'b1);
    chk("modechg2_locked", int'(lk), 0);
    chk("modechg2_seq_err", int'(se), 0);
    chk("modechg2_err_cnt", int'(ec), 6);
    for (int i = 0; i < 8; i++) begin up_y = shift(up_y, 1'b0); cyc(up_y, 1'b0, 1'b1); end
    chk("ring_relock_lit", int'(lk), 1);

    // Randomized traffic.
    mode = 1'b0;
    for (int i = 0; i < 400; i++) begin
      int r;
      logic s;
      r = $urandom_range(0, 99);
      if (r < 3) begin mode = ~mode; up_y = mode ? W'(0) : W'(1); end
      s = ($urandom_range(0, 3) != 0);
      if (s) up_y = shift(up_y, mode);
      if (r >= 3 && r < 8) cyc(W'($urandom), mode, s);
      else cyc(up_y, mode, s);
    end

    // Relock in ring, then asynchronous reset between edges.
    up_y = W'(1);
    cyc(up_y, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin up_y = shift(up_y, 1'b0); cyc(up_y, 1'b0, 1'b1); end
    chk("prereset_locked", int'(lk), 1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_pos", int'(pos), 0);
    chk("arst_pos_valid", int'(pv), 0);
    chk("arst_illegal", int'(ill), 0);
    chk("arst_seq_err", int'(se), 0);
    chk("arst_wrap", int'(wr), 0);
    chk("arst_locked", int'(lk), 0);
    chk("arst_err_cnt", int'(ec), 0);
    chk("arst_err_cnt_e2", int'(ec2), 0);
    @(negedge clk);
    rstn = 1'b1;
    up_y = W'(1);
    cyc(up_y, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin up_y = shift(up_y, 1'b0); cyc(up_y, 1'b0, 1'b1); end
    chk("postreset_locked", int'(lk), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
